key_mapper: RTL and testbench

Converts the PS/2 keyboard decoder's 11-bit `key_event` stream into per-player one-cycle command pulses, adding software auto-repeat for move and drop keys. It sits between `keyboard` and the two `player` controllers and `TIMER`, replacing the inline decode in the top level. The `player`, `TIMER` and `DDP` blocks see only clean, debounced, rate-limited pulses.

---
 rtl/tetris_keys_pkg.sv | 54 +++++
 rtl/key_repeat.sv | 59 +++++
 rtl/key_mapper.sv | 127 ++++++++++++
 tb/tb_key_mapper.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_keys_pkg.sv
// Shared key_event field positions, PS/2 scancodes and held-vector bit indices for the key mapper.
// Pure constants and a decode helper; no state, no latency, no flow control.
package tetris_keys_pkg;

  localparam int KE_VALID = 10;
  localparam int KE_EXT   = 9;
  localparam int KE_BRK   = 8;

  localparam logic [7:0] SC_W1    = 8'h1D;
  localparam logic [7:0] SC_A1    = 8'h1C;
  localparam logic [7:0] SC_S1    = 8'h1B;
  localparam logic [7:0] SC_D1    = 8'h23;
  localparam logic [7:0] SC_W2    = 8'h75;
  localparam logic [7:0] SC_A2    = 8'h6B;
  localparam logic [7:0] SC_S2    = 8'h72;
  localparam logic [7:0] SC_D2    = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_P     = 8'h4D;

  localparam int HB_W1 = 0;
  localparam int HB_A1 = 1;
  localparam int HB_S1 = 2;
  localparam int HB_D1 = 3;
  localparam int HB_W2 = 4;
  localparam int HB_A2 = 5;
  localparam int HB_S2 = 6;
  localparam int HB_D2 = 7;
  localparam int KEYS_PER_PLAYER = 4;

  // Player-1 keys only match without E0, player-2 (arrow) keys only with E0.
  function automatic logic [7:0] key_onehot(input logic ext, input logic [7:0] code);
    logic [7:0] oh;
    oh = '0;
    if (!ext) begin
      case (code)
        SC_W1:   oh[HB_W1] = 1'b1;
        SC_A1:   oh[HB_A1] = 1'b1;
        SC_S1:   oh[HB_S1] = 1'b1;
        SC_D1:   oh[HB_D1] = 1'b1;
        default: ;
      endcase
    end else begin
      case (code)
        SC_W2:   oh[HB_W2] = 1'b1;
        SC_A2:   oh[HB_A2] = 1'b1;
        SC_S2:   oh[HB_S2] = 1'b1;
        SC_D2:   oh[HB_D2] = 1'b1;
        default: ;
      endcase
    end
    return oh;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// One auto-repeat key: held flag plus 8-bit tick counter; rpt is combinational and registered by the top.
// Latency 0 from tick to rpt; no backpressure, the repeat strobe is fire-and-forget.
module key_repeat
  import tetris_keys_pkg::*;
#(
  parameter int DELAY_T = 250,
  parameter int RATE_T  = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  input  logic rel,
  input  logic tick,
  input  logic lock,
  output logic held,
  output logic rpt
);

  localparam logic [7:0] THRESH = 8'(DELAY_T);
  localparam logic [7:0] RELOAD = 8'(DELAY_T - RATE_T);

  logic       held_q, held_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;

  // Break beats everything; a typematic make on a held key falls through to the tick path.
  always_comb begin
    held_d  = held_q;
    cnt_d   = cnt_q;
    rpt     = 1'b0;
    cnt_inc = cnt_q + 8'd1;
    if (rel) begin
      held_d = 1'b0;
      cnt_d  = '0;
    end else if (press && !held_q) begin
      held_d = 1'b1;
      cnt_d  = '0;
    end else if (held_q && tick && !lock) begin
      if (cnt_inc == THRESH) begin
        rpt   = 1'b1;
        cnt_d = RELOAD;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      held_q <= held_d;
      cnt_q  <= cnt_d;
    end
  end

  assign held = held_q;

endmodule

// File: rtl/key_mapper.sv
// Decodes PS/2 key_event into per-player command pulses with auto-repeat on a/s/d keys.
// Latency 1 cycle, all outputs registered; no backpressure, pulses are fire-and-forget.
module key_mapper
  import tetris_keys_pkg::*;
#(
  parameter int PRESCALE = 100_000,
  parameter int DELAY_T  = 250,
  parameter int RATE_T   = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] key_event,
  output logic        w1,
  output logic        a1,
  output logic        s1,
  output logic        d1,
  output logic        w2,
  output logic        a2,
  output logic        s2,
  output logic        d2,
  output logic        start,
  output logic        pause,
  output logic [7:0]  held
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  if (!(RATE_T >= 1 && RATE_T <= DELAY_T && DELAY_T <= 255 && RATE_T * PRESCALE >= 2))
  begin : g_bad_param
    $error("key_mapper: repeat parameters out of range");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  always_comb begin
    tick    = (presc_q == PW'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  logic       ev_vld, ev_ext, ev_brk;
  logic [7:0] ev_code, hit, make, brk;

  always_comb begin
    ev_vld  = key_event[KE_VALID];
    ev_ext  = key_event[KE_EXT];
    ev_brk  = key_event[KE_BRK];
    ev_code = key_event[7:0];
    hit     = ev_vld ? key_onehot(ev_ext, ev_code) : '0;
    make    = hit & {8{~ev_brk}};
    brk     = hit & {8{ev_brk}};
  end

  logic [7:0] held_vec, rpt;

  for (genvar i = 0; i < 8; i++) begin : g_key
    if (i % KEYS_PER_PLAYER == HB_W1) begin : g_rot
      // Rotate keys never repeat, so they only need a held flag to suppress typematic makes.
      logic held_q, held_d;
      always_comb begin
        held_d = held_q;
        if (brk[i])       held_d = 1'b0;
        else if (make[i]) held_d = 1'b1;
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) held_q <= 1'b0;
        else     held_q <= held_d;
      end
      assign held_vec[i] = held_q;
      assign rpt[i]      = 1'b0;
    end else begin : g_rep
      localparam int BASE = (i / KEYS_PER_PLAYER) * KEYS_PER_PLAYER;
      logic lock;
      assign lock = (i % KEYS_PER_PLAYER != HB_S1) ?
                    (held_vec[BASE + HB_A1] & held_vec[BASE + HB_D1]) : 1'b0;
      key_repeat #(
        .DELAY_T (DELAY_T),
        .RATE_T  (RATE_T)
      ) u_rep (
        .clk   (clk),
        .rst   (rst),
        .press (make[i]),
        .rel   (brk[i]),
        .tick  (tick),
        .lock  (lock),
        .held  (held_vec[i]),
        .rpt   (rpt[i])
      );
    end
  end

  logic [7:0] pulse_q, pulse_d;
  logic       start_q, start_d, pause_q, pause_d;

  always_comb begin
    pulse_d = (make & ~held_vec) | rpt;
    start_d = ev_vld && !ev_ext && !ev_brk && (ev_code == SC_SPACE);
    pause_d = ev_vld && !ev_ext && !ev_brk && (ev_code == SC_P);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      pulse_q <= '0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pulse_q <= pulse_d;
      start_q <= start_d;
      pause_q <= pause_d;
    end
  end

  assign w1    = pulse_q[HB_W1];
  assign a1    = pulse_q[HB_A1];
  assign s1    = pulse_q[HB_S1];
  assign d1    = pulse_q[HB_D1];
  assign w2    = pulse_q[HB_W2];
  assign a2    = pulse_q[HB_A2];
  assign s2    = pulse_q[HB_S2];
  assign d2    = pulse_q[HB_D2];
  assign start = start_q;
  assign pause = pause_q;
  assign held  = held_vec;

endmodule

// File: tb/tb_key_mapper.sv
// Scoreboard bench for key_mapper: exact-cycle pulse expectations queued at stimulus time,
// plus pulse-count windows for hold, lock, repeat and reset scenarios.
module tb_key_mapper;
  import tetris_keys_pkg::*;

  localparam int PRESCALE = 4;
  localparam int DELAY_T  = 3;
  localparam int RATE_T   = 2;

  localparam int O_W1 = 0, O_A1 = 1, O_S1 = 2, O_D1 = 3;
  localparam int O_W2 = 4, O_A2 = 5, O_S2 = 6, O_D2 = 7;
  localparam int O_START = 8, O_PAUSE = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] key_event = '0;
  logic        w1, a1, s1, d1, w2, a2, s2, d2, start, pause;
  logic [7:0]  held;
  logic [9:0]  outv;

  always #5 clk = ~clk;

  key_mapper #(
    .PRESCALE (PRESCALE),
    .DELAY_T  (DELAY_T),
    .RATE_T   (RATE_T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_event (key_event),
    .w1        (w1),
    .a1        (a1),
    .s1        (s1),
    .d1        (d1),
    .w2        (w2),
    .a2        (a2),
    .s2        (s2),
    .d2        (d2),
    .start     (start),
    .pause     (pause),
    .held      (held)
  );

  assign outv = {pause, start, d2, s2, a2, w2, d1, s1, a1, w1};

  typedef struct {
    int         due;
    bit         is_held;
    logic [9:0] mask;
    logic [9:0] val;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         cnt[10] = '{default: 0};
  logic [9:0] prev_outv = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic exp_out(input int due, input int b, input logic v, input string tag);
    exp_t e;
    e.due = due; e.is_held = 1'b0; e.mask = '0; e.mask[b] = 1'b1;
    e.val = '0; e.val[b] = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic exp_held(input int due, input logic [7:0] mask, input logic [7:0] val,
                          input string tag);
    exp_t e;
    e.due = due; e.is_held = 1'b1; e.mask = {2'b00, mask}; e.val = {2'b00, val}; e.tag = tag;
    sb.push_back(e);
  endtask

  // Drive one key_event for exactly one cycle; call at a negedge.
  task automatic send(input logic ext, input logic brk, input logic [7:0] code);
    key_event = {1'b1, ext, brk, code};
    @(negedge clk);
    key_event = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // cyc = number of rising edges since reset release; the DUT prescaler tracks cyc mod 4.
  always @(posedge clk) begin
    if (rst) cyc = 0;
    else     cyc++;
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_outv = '0;
    end else begin
      for (int b = 0; b < 10; b++) if (outv[b] === 1'b1) cnt[b]++;
      chk("no_back_to_back", 32'(outv & prev_outv), 32'd0);
      prev_outv = outv;
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].due < cyc) begin
          chk({sb[k].tag, "_missed"}, 32'(cyc), 32'(sb[k].due));
          sb.delete(k);
        end else if (sb[k].due == cyc) begin
          if (sb[k].is_held) chk(sb[k].tag, 32'({2'b00, held} & sb[k].mask), 32'(sb[k].val));
          else               chk(sb[k].tag, 32'(outv & sb[k].mask), 32'(sb[k].val));
          sb.delete(k);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, c0, c1, n;
    repeat (3) @(negedge clk);
    chk("rst_pulses", 32'(outv), 32'd0);
    chk("rst_held", 32'(held), 32'd0);
    rst = 1'b0;
    idle(8);

    // a1 make then break
    c0 = cnt[O_A1];
    e = cyc + 1;
    exp_out(e, O_A1, 1'b1, "a1_make");
    exp_out(e + 1, O_A1, 1'b0, "a1_make_width");
    exp_held(e, 8'h02, 8'h02, "a1_held_set");
    send(1'b0, 1'b0, SC_A1);
    idle(3);
    e = cyc + 1;
    exp_out(e, O_A1, 1'b0, "a1_break_no_pulse");
    exp_held(e, 8'h02, 8'h00, "a1_held_clr");
    send(1'b0, 1'b1, SC_A1);
    idle(20);
    chk("a1_total", 32'(cnt[O_A1] - c0), 32'd1);

    // a2 held for 100 cycles with auto-repeat
    c0 = cnt[O_A2];
    e = cyc + 1;
    exp_out(e, O_A2, 1'b1, "a2_make");
    send(1'b1, 1'b0, SC_A2);
    idle(98);
    send(1'b1, 1'b1, SC_A2);
    idle(10);
    n = cnt[O_A2] - c0;
    chk("a2_count_in_12_13", 32'(n >= 12 && n <= 13), 32'd1);

    // w1 held for 100 cycles: never repeats
    c0 = cnt[O_W1];
    e = cyc + 1;
    exp_out(e, O_W1, 1'b1, "w1_make");
    send(1'b0, 1'b0, SC_W1);
    idle(99);
    send(1'b0, 1'b1, SC_W1);
    idle(4);
    chk("w1_single", 32'(cnt[O_W1] - c0), 32'd1);

    // wrong extended prefix, start and pause
    c0 = cnt[O_W2];
    c1 = cnt[O_W1];
    e = cyc + 1;
    exp_out(e, O_W2, 1'b0, "w2_without_e0");
    exp_held(e, 8'hFF, 8'h00, "w2_without_e0_held");
    send(1'b0, 1'b0, SC_W2);
    idle(2);
    e = cyc + 1;
    exp_out(e, O_W1, 1'b0, "w1_with_e0");
    send(1'b1, 1'b0, SC_W1);
    idle(2);
    n = cnt[O_START];
    e = cyc + 1;
    exp_out(e, O_START, 1'b1, "start_make");
    exp_out(e + 1, O_START, 1'b0, "start_width");
    exp_held(e, 8'hFF, 8'h00, "start_held");
    send(1'b0, 1'b0, SC_SPACE);
    idle(2);
    e = cyc + 1;
    exp_out(e, O_START, 1'b0, "start_break");
    send(1'b0, 1'b1, SC_SPACE);
    idle(2);
    e = cyc + 1;
    exp_out(e, O_PAUSE, 1'b1, "pause_make");
    exp_out(e + 1, O_PAUSE, 1'b0, "pause_width");
    send(1'b0, 1'b0, SC_P);
    idle(20);
    chk("w2_noext_cnt", 32'(cnt[O_W2] - c0), 32'd0);
    chk("w1_ext_cnt", 32'(cnt[O_W1] - c1), 32'd0);
    chk("start_cnt", 32'(cnt[O_START] - n), 32'd1);

    // opposite-direction lock
    c0 = cnt[O_A1];
    c1 = cnt[O_D1];
    e = cyc + 1;
    exp_out(e, O_A1, 1'b1, "lock_a1_make");
    send(1'b0, 1'b0, SC_A1);
    e = cyc + 1;
    exp_out(e, O_D1, 1'b1, "lock_d1_make");
    exp_held(e, 8'h0A, 8'h0A, "lock_held");
    send(1'b0, 1'b0, SC_D1);
    idle(100);
    chk("lock_a1_cnt", 32'(cnt[O_A1] - c0), 32'd1);
    chk("lock_d1_cnt", 32'(cnt[O_D1] - c1), 32'd1);
    send(1'b0, 1'b1, SC_D1);
    c0 = cnt[O_A1];
    idle(40);
    n = cnt[O_A1] - c0;
    chk("unlock_a1_in_4_5", 32'(n >= 4 && n <= 5), 32'd1);
    send(1'b0, 1'b1, SC_A1);
    idle(10);

    // typematic re-make while held
    c0 = cnt[O_A1];
    e = cyc + 1;
    exp_out(e, O_A1, 1'b1, "dup_first");
    send(1'b0, 1'b0, SC_A1);
    exp_out(cyc + 1, O_A1, 1'b0, "dup_second");
    send(1'b0, 1'b0, SC_A1);
    exp_out(cyc + 1, O_A1, 1'b0, "dup_third");
    send(1'b0, 1'b0, SC_A1);
    send(1'b0, 1'b1, SC_A1);
    idle(10);
    chk("dup_cnt", 32'(cnt[O_A1] - c0), 32'd1);

    // exact repeat timing, then break on a threshold tick
    while (((cyc + 1) % 4) != 1) @(negedge clk);
    c0 = cnt[O_A1];
    e = cyc + 1;
    exp_out(e, O_A1, 1'b1, "rep_make");
    exp_out(e + 10, O_A1, 1'b0, "rep_not_early");
    exp_out(e + 11, O_A1, 1'b1, "rep_first");
    exp_out(e + 12, O_A1, 1'b0, "rep_first_width");
    exp_out(e + 18, O_A1, 1'b0, "rep_second_not_early");
    exp_out(e + 19, O_A1, 1'b1, "rep_second");
    send(1'b0, 1'b0, SC_A1);
    while (cyc + 1 != e + 27) @(negedge clk);
    exp_out(e + 27, O_A1, 1'b0, "break_beats_repeat");
    exp_held(e + 27, 8'h02, 8'h00, "break_beats_repeat_held");
    send(1'b0, 1'b1, SC_A1);
    idle(20);
    chk("rep_total", 32'(cnt[O_A1] - c0), 32'd3);

    // reset while s1 is repeating
    e = cyc + 1;
    exp_out(e, O_S1, 1'b1, "s1_make");
    send(1'b0, 1'b0, SC_S1);
    idle(30);
    chk("sb_drained_before_rst", 32'(sb.size()), 32'd0);
    chk("s1_held_before_rst", 32'(held), 32'h04);
    rst = 1'b1;
    #1;
    chk("rst_mid_pulses", 32'(outv), 32'd0);
    chk("rst_mid_held", 32'(held), 32'd0);
    idle(2);
    rst = 1'b0;
    c0 = cnt[O_S1];
    idle(40);
    chk("s1_after_rst", 32'(cnt[O_S1] - c0), 32'd0);
    chk("held_after_rst", 32'(held), 32'd0);
    e = cyc + 1;
    exp_out(e, O_S1, 1'b1, "s1_remake");
    exp_held(e, 8'h04, 8'h04, "s1_remake_held");
    send(1'b0, 1'b0, SC_S1);
    idle(2);
    send(1'b0, 1'b1, SC_S1);
    idle(5);

    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
